// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: bus bundle of the fetch unit -- RAM read port,
// decode-side valid/ready handshake and the jump/redirect strobe.
// master = fetch unit side, slave = RAM/decode/branch side.
interface instr_fetch_unit_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32
);
    logic              o_mem_rd;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [DATA_W-1:0] i_mem_data;
    logic [DATA_W-1:0] o_instr;
    logic [ADDR_W-1:0] o_instr_pc;
    logic              o_instr_valid;
    logic              i_instr_ready;
    logic              i_redirect;
    logic [ADDR_W-1:0] i_redirect_addr;

    modport master (
        output o_mem_rd,
        output o_mem_addr,
        input  i_mem_data,
        output o_instr,
        output o_instr_pc,
        output o_instr_valid,
        input  i_instr_ready,
        input  i_redirect,
        input  i_redirect_addr
    );

    modport slave (
        input  o_mem_rd,
        input  o_mem_addr,
        output i_mem_data,
        input  o_instr,
        input  o_instr_pc,
        input  o_instr_valid,
        output i_instr_ready,
        output i_redirect,
        output i_redirect_addr
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: streams instruction words from RAM into a small prefetch
// FIFO tagged with their PC; decode pops over valid/ready. A redirect flushes
// the FIFO, kills any read in flight and restarts fetching at the target.
// Optional build macro FETCH_HALT_EN: a fetched word with bits [31:27] all
// ones raises o_halted and parks the fetcher in HALT until redirect/reset.
module instr_fetch_unit #(
    parameter int unsigned       ADDR_W   = 16,
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_run,
    instr_fetch_unit_if.master bus,
    output logic               o_halted
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;
`ifdef FETCH_HALT_EN
    localparam logic [4:0]  HALT_OP = 5'b11111;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1
`ifdef FETCH_HALT_EN
        , S_HALT = 2'd2
`endif
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] word;
    } entry_t;

    state_t            state_q,    state_d;
    entry_t            fifo_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q,   rd_ptr_d;
    logic [CNT_W-1:0]  count_q,    count_d;
    logic              valid_q,    valid_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              mem_rd_q,   mem_rd_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    // resp_q: i_mem_data carries a live response this cycle for resp_pc_q
    logic              resp_q,     resp_d;
    logic [ADDR_W-1:0] resp_pc_q,  resp_pc_d;
    logic              halted_q,   halted_d;

    logic              push_c;
    logic              pop_c;
    logic [CNT_W-1:0]  inflight_c;
    entry_t            push_entry_c;
`ifdef FETCH_HALT_EN
    logic              halt_hit_c;
`endif

    assign push_entry_c = '{pc: resp_pc_q, word: bus.i_mem_data};

    // FSM state register
    always_ff @(posedge i_clk or posedge i_reset) begin : state_reg
        if (i_reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, read issue, response acceptance and FIFO bookkeeping
    always_comb begin : next_state_logic
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        mem_rd_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        resp_d     = mem_rd_q;
        resp_pc_d  = mem_addr_q;
        halted_d   = halted_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        valid_d    = valid_q;
        push_c     = resp_q;
        pop_c      = valid_q & bus.i_instr_ready;
        inflight_c = CNT_W'(mem_rd_q) + CNT_W'(resp_q);
`ifdef FETCH_HALT_EN
        halt_hit_c = 1'b0;
`endif

        case (state_q)
            S_IDLE: if (i_run) state_d = S_RUN;
            S_RUN:  if (!i_run) state_d = S_IDLE;
`ifdef FETCH_HALT_EN
            S_HALT: state_d = S_HALT;
`endif
            default: state_d = S_IDLE;
        endcase

`ifdef FETCH_HALT_EN
        // Halt word is still queued; the response behind it is dropped
        halt_hit_c = push_c && (bus.i_mem_data[DATA_W-1 -: 5] == HALT_OP);
        if (halt_hit_c) begin
            state_d  = S_HALT;
            halted_d = 1'b1;
            resp_d   = 1'b0;
        end
`endif

        // Redirect overrides everything: flush, kill in-flight read, retarget
        if (bus.i_redirect) begin
            state_d    = i_run ? S_RUN : S_IDLE;
            fetch_pc_d = bus.i_redirect_addr;
            halted_d   = 1'b0;
            resp_d     = 1'b0;
            push_c     = 1'b0;
            pop_c      = 1'b0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        end
        valid_d = (count_d != '0);

        // Credit check: queued plus outstanding words must leave a free slot
        if ((state_d == S_RUN) && !bus.i_redirect &&
            ((SUM_W'(count_q) + SUM_W'(inflight_c)) < SUM_W'(DEPTH))) begin
            mem_rd_d   = 1'b1;
            mem_addr_d = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + ADDR_W'(1);
        end
    end

    // Fetch datapath and FIFO control registers
    always_ff @(posedge i_clk or posedge i_reset) begin : ctrl_regs
        if (i_reset) begin
            fetch_pc_q <= RESET_PC;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            resp_q     <= 1'b0;
            resp_pc_q  <= '0;
            halted_q   <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
            resp_q     <= resp_d;
            resp_pc_q  <= resp_pc_d;
            halted_q   <= halted_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
        end
    end

    // Prefetch storage; cleared on reset so the head reads zero
    always_ff @(posedge i_clk or posedge i_reset) begin : fifo_storage
        if (i_reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else if (push_c) begin
            fifo_q[wr_ptr_q] <= push_entry_c;
        end
    end

    assign bus.o_mem_rd      = mem_rd_q;
    assign bus.o_mem_addr    = mem_addr_q;
    assign bus.o_instr       = fifo_q[rd_ptr_q].word;
    assign bus.o_instr_pc    = fifo_q[rd_ptr_q].pc;
    assign bus.o_instr_valid = valid_q;
    assign o_halted          = halted_q;

endmodule
